ring_fifo: RTL
==============

Name: ring_fifo

Overview:
- Circular-buffer FIFO that consumes the modulo pointer counter. Two counter instances form the head and tail pointers, sized BOUND = DEPTH.
- Sits between a producer stage, such as decode or issue, and a consumer stage. Used for instruction queues and ROB-style buffers.
- Uses valid/ready handshakes on both sides, a single-cycle flush, and supports any DEPTH ≥ 1, not only powers of two.

Parameters:
- DEPTH, 4, number of entries; ≥ 1.
- DATA_WIDTH, 32, payload width in bits.
- PTR_WIDTH, DEPTH == 1 ? 1 : $clog2(DEPTH), pointer width; derived, do not override.
- CNT_WIDTH, $clog2(DEPTH+1), occupancy width; derived.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all entries.
- enq_valid  in  1  producer offers enq_data.
- enq_ready  out  1  FIFO can accept an entry.
- enq_data  in  DATA_WIDTH  payload to store.
- deq_valid  out  1  head entry valid.
- deq_ready  in  1  consumer takes the head entry.
- deq_data  out  DATA_WIDTH  payload at the head.
- count  out  CNT_WIDTH  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst low, asynchronous assertion):
  - head = 0, tail = 0, count = 0.
  - deq_valid = 0, enq_ready = 1.
  - Storage contents are not reset.
  - The counter sub-module takes an active-high reset, so instances are driven with !rst.
- Handshakes:
  - enq_fire = enq_valid & enq_ready.
  - deq_fire = deq_valid & deq_ready.
  - enq_ready = (count != DEPTH). It is independent of deq_ready: no same-cycle bypass when full.
  - deq_valid = (count != 0). It is independent of enq_valid: no fall-through when empty.
- Latency: an entry written on cycle N is visible on deq_data/deq_valid at cycle N+1.
- Read path: deq_data = mem[head], combinational from storage. It is don't-care while deq_valid = 0.
- On enq_fire:
  - mem[tail] <= enq_data.
  - tail advances via counter tick, wrapping from DEPTH-1 to 0.
- On deq_fire: head advances via counter tick, wrapping the same way.
- Count update:
  - enq_fire only: count + 1.
  - deq_fire only: count - 1.
  - Both: count unchanged, both pointers advance.
  - Neither: hold.
- Full (count = DEPTH): enq_ready = 0. deq_fire alone is legal, and enq_ready rises the following cycle.
- Empty (count = 0): deq_valid = 0. An enq_fire alone makes deq_valid = 1 the following cycle.
- Flush:
  - Highest priority. head, tail and count go to 0 the next cycle; the counters' flush input is driven with flush.
  - Any enq_fire or deq_fire in the same cycle is discarded, with no storage write side effects visible after flush.
  - Handshake outputs are not gated combinationally by flush.
- Reset mid-operation: asynchronous clear as above; all entries are lost.
- DEPTH = 1:
  - Pointers are constant 0, per the counter's degenerate case.
  - FIFO alternates full/empty and count is 1 bit.
- Non-power-of-two DEPTH (e.g. 3): pointers wrap at DEPTH-1 and never index unused storage.
- Assertions in the bench: count ≤ DEPTH at all times; count == 0 iff !deq_valid.

Decomposition:
- No shared package is required; the payload is a parameterized bit vector. Callers wanting structured payloads pack them from their own package types.
- Sub-module: counter, instantiated twice (head_ptr, tail_ptr):
  - BOUND = DEPTH.
  - tick = deq_fire or enq_fire respectively.
  - flush = flush, rst = !rst.
- Storage is an unpacked array of DEPTH × DATA_WIDTH flops in this module, with no RAM macro.
- The occupancy counter is local logic; the counter module is not used for it because it needs up/down behaviour.

Test Plan:
- Reset, then idle 3 cycles -> count = 0, deq_valid = 0, enq_ready = 1 throughout.
- DEPTH=4: enqueue 0xA0..0xA3 on consecutive cycles with deq_ready = 0 -> count steps 1,2,3,4; enq_ready = 0 after the 4th; a 5th offer 0xA4 is held and not accepted.
- From full, hold deq_ready = 1 for 4 cycles -> deq_data reads 0xA0,0xA1,0xA2,0xA3 in order; count returns to 0; deq_valid drops.
- DEPTH=3: 10 cycles of simultaneous enq/deq at count = 2, with data = cycle index -> count stays 2; output equals input delayed by 2 accepts; pointers wrap 2->0 without corruption.
- Enqueue 3 entries, then assert flush with enq_valid = 1 and deq_ready = 1 in the same cycle -> next cycle count = 0 and deq_valid = 0. A following enqueue of 0x55 dequeues as 0x55.
- Drive rst low asynchronously mid-burst at count = 2 -> count = 0 and deq_valid = 0 immediately, without waiting for a clock edge. Normal operation resumes after rst rises.

Source files
------------

// File: rtl/ring_fifo_pkg.sv
// Shared width helpers for the ring FIFO and its pointer counters.
// Keeping them here lets a DEPTH of 1 still produce a legal 1-bit pointer.
package ring_fifo_pkg;

  function automatic int ptr_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ring_fifo_counter.sv
// Modulo pointer counter: counts 0..BOUND-1 on tick and wraps to 0.
// With BOUND == 1 the wrap value is 0, so the output stays constant at 0.
module ring_fifo_counter
  import ring_fifo_pkg::*;
#(
  parameter int BOUND = 4,
  parameter int WIDTH = ptr_width(BOUND)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             tick,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(BOUND - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (flush) begin
      value <= '0;
    end else if (tick) begin
      value <= (value == LAST) ? '0 : value + WIDTH'(1);
    end
  end

endmodule

// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with valid/ready on both sides and a one-cycle flush.
// Works for any DEPTH >= 1; head and tail wrap at DEPTH-1, not at a power of two.
module ring_fifo
  import ring_fifo_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = ptr_width(DEPTH),
  parameter int CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [DATA_WIDTH-1:0] deq_data,
  output logic [CNT_WIDTH-1:0]  count
);

  localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_WIDTH-1:0]  head;
  logic [PTR_WIDTH-1:0]  tail;
  logic                  enq_fire;
  logic                  deq_fire;

  // No bypass in either direction: readiness depends only on occupancy.
  assign enq_ready = (count != FULL);
  assign deq_valid = (count != '0);
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;
  assign deq_data  = mem[head];

  ring_fifo_counter #(.BOUND(DEPTH), .WIDTH(PTR_WIDTH)) head_ptr (
    .clk   (clk),
    .rst   (!rst),
    .flush (flush),
    .tick  (deq_fire),
    .value (head)
  );

  ring_fifo_counter #(.BOUND(DEPTH), .WIDTH(PTR_WIDTH)) tail_ptr (
    .clk   (clk),
    .rst   (!rst),
    .flush (flush),
    .tick  (enq_fire),
    .value (tail)
  );

  // Storage is deliberately unreset; a write in a flush cycle is suppressed.
  always_ff @(posedge clk) begin
    if (enq_fire && !flush) begin
      mem[tail] <= enq_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else if (enq_fire && !deq_fire) begin
      count <= count + CNT_WIDTH'(1);
    end else if (deq_fire && !enq_fire) begin
      count <= count - CNT_WIDTH'(1);
    end
  end

endmodule
